// File: rtl/gcfifo_ctrl.sv
// Gray-pointer controller for a single-clock FIFO. It drives an external storage array and exports flags and occupancy.
// Define GCFIFO_ERR_STICKY_EN to make overflow/underflow sticky until reset.
module gcfifo_ctrl #(
   parameter int ADDR_W    = 3,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   wr_ptr_gray,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);
   localparam logic [ADDR_W:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR_W:0] wrBin_q, wrBin_d;
   logic [ADDR_W:0] rdBin_q, rdBin_d;
   logic [ADDR_W:0] wrGray_q, wrGray_d;
   logic [ADDR_W:0] rdGray_q, rdGray_d;
   logic [ADDR_W:0] count_q, count_d;
   logic            fullGray_q, fullGray_d;
   logic            emptyGray_q, emptyGray_d;
   logic            afull_q, afull_d;
   logic            aempty_q, aempty_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic            pushAcc, popAcc;
   logic            ovfEvent, unfEvent;

   // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
   always_comb begin
      pushAcc  = push & (~fullGray_q | pop);
      popAcc   = pop & ~emptyGray_q;
      ovfEvent = push & ~pushAcc & ~flush;
      unfEvent = pop & ~popAcc & ~flush;
      wr_en    = pushAcc & ~flush & ~rst;
   end

   always_comb begin
      wrBin_d = wrBin_q;
      rdBin_d = rdBin_q;
      if (flush) begin
         wrBin_d = '0;
         rdBin_d = '0;
      end else begin
         if (pushAcc) wrBin_d = wrBin_q + PTR_ONE;
         if (popAcc)  rdBin_d = rdBin_q + PTR_ONE;
      end
      wrGray_d    = wrBin_d ^ (wrBin_d >> 1);
      rdGray_d    = rdBin_d ^ (rdBin_d >> 1);
      count_d     = wrBin_d - rdBin_d;
      // Flags come from the gray pointers so the dual-clock variant can reuse this comparison.
      fullGray_d  = (wrGray_d == (rdGray_d ^ FULL_MASK));
      emptyGray_d = (wrGray_d == rdGray_d);
      afull_d     = (count_d >= AFULL_LV);
      aempty_d    = (count_d <= AEMPTY_LV);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (pushAcc) state_d = ST_PARTIAL;
         end
         ST_PARTIAL: begin
            if (count_d == DEPTH)   state_d = ST_FULL;
            else if (count_d == '0) state_d = ST_EMPTY;
         end
         ST_FULL: begin
            if (popAcc && !pushAcc) state_d = ST_PARTIAL;
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
   end

`ifdef GCFIFO_ERR_STICKY_EN
   logic [3:0] errCnt_q, errCnt_d;

   // Error flags and the saturating error tally survive flush and clear only on reset.
   always_comb begin
      ovf_d    = ovf_q | ovfEvent;
      unf_d    = unf_q | unfEvent;
      errCnt_d = errCnt_q;
      if ((ovfEvent || unfEvent) && (errCnt_q != 4'hF)) errCnt_d = errCnt_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) errCnt_q <= '0;
      else     errCnt_q <= errCnt_d;
   end
`else
   always_comb begin
      ovf_d = ovfEvent;
      unf_d = unfEvent;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         wrBin_q     <= '0;
         rdBin_q     <= '0;
         wrGray_q    <= '0;
         rdGray_q    <= '0;
         count_q     <= '0;
         fullGray_q  <= 1'b0;
         emptyGray_q <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrBin_q     <= wrBin_d;
         rdBin_q     <= rdBin_d;
         wrGray_q    <= wrGray_d;
         rdGray_q    <= rdGray_d;
         count_q     <= count_d;
         fullGray_q  <= fullGray_d;
         emptyGray_q <= emptyGray_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign wr_addr      = wrBin_q[ADDR_W-1:0];
   assign rd_addr      = rdBin_q[ADDR_W-1:0];
   assign wr_ptr_gray  = wrGray_q;
   assign rd_ptr_gray  = rdGray_q;
   assign full         = (state_q == ST_FULL);
   assign empty        = (state_q == ST_EMPTY);
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_gcfifo_ctrl.sv
// Self-checking bench for gcfifo_ctrl: directed steps plus random traffic, checked against an occupancy/op-count model.
module tb_gcfifo_ctrl;

   logic       clk;
   logic       rst;
   logic       push;
   logic       pop;
   logic       flush;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [2:0] rd_addr;
   logic [3:0] wr_ptr_gray;
   logic [3:0] rd_ptr_gray;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int assertCount = 0;
   int failCount   = 0;

   // Model: number of accepted pushes/pops (mod 16) and the occupancy.
   int  mWr  = 0;
   int  mRd  = 0;
   int  mCnt = 0;
   bit  mOvf = 0;
   bit  mUnf = 0;
   bit  modelValid = 0;
   logic [3:0] prevWg = '0;
   logic [3:0] prevRg = '0;

   gcfifo_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .pop          (pop),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .rd_addr      (rd_addr),
      .wr_ptr_gray  (wr_ptr_gray),
      .rd_ptr_gray  (rd_ptr_gray),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] toGray(input int n);
      logic [3:0] b;
      b = 4'(n % 16);
      return b ^ (b >> 1);
   endfunction

   task automatic checkOutput(input bit ptrJump);
      check("count", count, 32'(mCnt));
      check("full", full, 32'(mCnt == 8));
      check("empty", empty, 32'(mCnt == 0));
      check("almost_full", almost_full, 32'(mCnt >= 6));
      check("almost_empty", almost_empty, 32'(mCnt <= 2));
      check("wr_ptr_gray", wr_ptr_gray, toGray(mWr));
      check("rd_ptr_gray", rd_ptr_gray, toGray(mRd));
      check("overflow", overflow, 32'(mOvf));
      check("underflow", underflow, 32'(mUnf));
      if (!ptrJump) begin
         check("wr_gray_step", 32'($countones(wr_ptr_gray ^ prevWg) <= 1), 32'd1);
         check("rd_gray_step", 32'($countones(rd_ptr_gray ^ prevRg) <= 1), 32'd1);
      end
      prevWg = wr_ptr_gray;
      prevRg = rd_ptr_gray;
   endtask

   // One clock: drive at negedge, check combinational strobes, update model, check registered outputs.
   task automatic applyStimulus(input bit p, input bit q, input bit f, input bit r);
      bit pa, pp, ovfEv, unfEv;
      @(negedge clk);
      push  = p;
      pop   = q;
      flush = f;
      rst   = r;
      pa = p && (mCnt < 8 || q);
      pp = q && (mCnt > 0);
      #1;
      check("wr_en", wr_en, 32'(pa && !f && !r));
      if (modelValid) begin
         check("wr_addr", wr_addr, 32'(mWr % 8));
         check("rd_addr", rd_addr, 32'(mRd % 8));
      end
      ovfEv = p && !pa && !f;
      unfEv = q && !pp && !f;
      if (r) begin
         mWr = 0; mRd = 0; mCnt = 0; mOvf = 0; mUnf = 0;
         modelValid = 1;
      end else if (f) begin
         mWr = 0; mRd = 0; mCnt = 0;
`ifndef GCFIFO_ERR_STICKY_EN
         mOvf = 0; mUnf = 0;
`endif
      end else begin
`ifdef GCFIFO_ERR_STICKY_EN
         mOvf = mOvf | ovfEv;
         mUnf = mUnf | unfEv;
`else
         mOvf = ovfEv;
         mUnf = unfEv;
`endif
         mWr  = (mWr + int'(pa)) % 16;
         mRd  = (mRd + int'(pp)) % 16;
         mCnt = mCnt + int'(pa) - int'(pp);
      end
      @(posedge clk);
      #1;
      checkOutput(r || f);
   endtask

   initial begin
      push = 0; pop = 0; flush = 0; rst = 0;
      $display("[TB] reset");
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] fill with 8 pushes");
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
      check("gray_after_fill", wr_ptr_gray, 32'h0000000C);
      check("full_after_fill", full, 32'd1);

      $display("[TB] push into full");
      applyStimulus(1, 0, 0, 0);
      check("overflow_pulse", overflow, 32'd1);
      applyStimulus(0, 0, 0, 0);

      $display("[TB] push+pop while full");
      applyStimulus(1, 1, 0, 0);
      check("rd_addr_advanced", rd_addr, 32'd1);
      check("still_full", full, 32'd1);

      $display("[TB] drain, then push+pop while empty");
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      check("underflow_pulse", underflow, 32'd1);
      check("count_one", count, 32'd1);
      applyStimulus(0, 1, 0, 0);
      check("empty_again", empty, 32'd1);

      $display("[TB] bursts of 5 across pointer wrap");
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
         for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
      end

      $display("[TB] mid-burst flush and reset");
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 1, 0);
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         bit p, q, f;
         p = ($urandom_range(0, 99) < 55);
         q = ($urandom_range(0, 99) < 50);
         f = ($urandom_range(0, 59) == 0);
         applyStimulus(p, q, f, 1'b0);
      end
      applyStimulus(0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
